// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Round-robin sharing of one single-port synchronous RAM between
//            an instruction-fetch port (m0) and a data/loader port (m1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int MEM_AW  = 10,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req,
    input  logic [31:0]       m0_addr,
    input  logic [31:0]       m0_wdata,
    input  logic [3:0]        m0_wstrb,
    output logic              m0_ready,
    output logic [31:0]       m0_rdata,

    input  logic              m1_req,
    input  logic [31:0]       m1_addr,
    input  logic [31:0]       m1_wdata,
    input  logic [3:0]        m1_wstrb,
    output logic              m1_ready,
    output logic [31:0]       m1_rdata,

    output logic              mem_en,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic [31:0]       mem_rdata,

    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic               r_prio;
    logic               r_gnt;
    logic               r_is_write;
    logic [2:0]         r_cnt;

    logic               w_grant;
    logic               w_sel;
    logic [MEM_AW-1:0]  w_cmd_addr;
    logic [31:0]        w_cmd_wdata;
    logic [3:0]         w_cmd_wstrb;

    // Byte-offset and high address bits are deliberately ignored.
    logic               w_unused_addr;
    assign w_unused_addr = ^{m0_addr[1:0], m1_addr[1:0],
                             m0_addr[31:MEM_AW+2], m1_addr[31:MEM_AW+2]};

    always_comb begin
        w_grant     = m0_req | m1_req;
        w_sel       = (m0_req && m1_req) ? r_prio : m1_req;
        w_cmd_addr  = w_sel ? m1_addr[MEM_AW+1:2] : m0_addr[MEM_AW+1:2];
        w_cmd_wdata = w_sel ? m1_wdata : m0_wdata;
        w_cmd_wstrb = w_sel ? m1_wstrb : m0_wstrb;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_grant) w_state_next = S_ISSUE;
            S_ISSUE: w_state_next = S_WAIT;
            S_WAIT:  if (r_cnt == 3'd1) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Command, response and status registers; every output comes from here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prio     <= 1'b0;
            r_gnt      <= 1'b0;
            r_is_write <= 1'b0;
            r_cnt      <= 3'd0;
            mem_en     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
            m0_ready   <= 1'b0;
            m1_ready   <= 1'b0;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
            busy       <= 1'b0;
        end else begin
            busy <= (w_state_next != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_gnt      <= w_sel;
                        r_prio     <= ~w_sel;
                        r_is_write <= |w_cmd_wstrb;
                        mem_addr   <= w_cmd_addr;
                        mem_wdata  <= w_cmd_wdata;
                        mem_wstrb  <= w_cmd_wstrb;
                        mem_en     <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    mem_en    <= 1'b0;
                    mem_wstrb <= '0;
                    r_cnt     <= 3'(LATENCY);
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 3'd1;
                    if (r_cnt == 3'd1) begin
                        if (!r_is_write) begin
                            if (r_gnt) m1_rdata <= mem_rdata;
                            else       m0_rdata <= mem_rdata;
                        end
                        m0_ready <= ~r_gnt;
                        m1_ready <= r_gnt;
                    end
                end
                S_DONE: begin
                    m0_ready <= 1'b0;
                    m1_ready <= 1'b0;
                end
                default: begin
                    mem_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Self-checking bench for mem_port_arbiter at LATENCY 1 and 3.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    // Index [inst][port]; inst 0 is LATENCY=1, inst 1 is LATENCY=3.
    logic        req   [2][2];
    logic [31:0] addr  [2][2];
    logic [31:0] wdata [2][2];
    logic [3:0]  wstrb [2][2];
    logic        ready [2][2];
    logic [31:0] rdata [2][2];
    logic        mem_en    [2];
    logic [9:0]  mem_addr  [2];
    logic [31:0] mem_wdata [2];
    logic [3:0]  mem_wstrb [2];
    logic [31:0] mem_rdata [2];
    logic        busy      [2];

    int          cur;
    int          n_chk;
    int          n_fail;
    int          exp_prio;
    logic [31:0] exp_rd  [2];
    logic [31:0] ref_mem [1024];

    int          cyc = 0;
    int          rd_due [2] = '{-1, -1};
    logic [31:0] rd_val [2];
    logic [31:0] mm     [1024];
    bit          mm_wr  [1024];

    mem_port_arbiter #(.MEM_AW(10), .LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst(rst),
        .m0_req(req[0][0]), .m0_addr(addr[0][0]), .m0_wdata(wdata[0][0]),
        .m0_wstrb(wstrb[0][0]), .m0_ready(ready[0][0]), .m0_rdata(rdata[0][0]),
        .m1_req(req[0][1]), .m1_addr(addr[0][1]), .m1_wdata(wdata[0][1]),
        .m1_wstrb(wstrb[0][1]), .m1_ready(ready[0][1]), .m1_rdata(rdata[0][1]),
        .mem_en(mem_en[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
        .mem_wstrb(mem_wstrb[0]), .mem_rdata(mem_rdata[0]), .busy(busy[0])
    );

    mem_port_arbiter #(.MEM_AW(10), .LATENCY(3)) u_dut_l3 (
        .clk(clk), .rst(rst),
        .m0_req(req[1][0]), .m0_addr(addr[1][0]), .m0_wdata(wdata[1][0]),
        .m0_wstrb(wstrb[1][0]), .m0_ready(ready[1][0]), .m0_rdata(rdata[1][0]),
        .m1_req(req[1][1]), .m1_addr(addr[1][1]), .m1_wdata(wdata[1][1]),
        .m1_wstrb(wstrb[1][1]), .m1_ready(ready[1][1]), .m1_rdata(rdata[1][1]),
        .mem_en(mem_en[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
        .mem_wstrb(mem_wstrb[1]), .mem_rdata(mem_rdata[1]), .busy(busy[1])
    );

    function automatic int lat_of(input int d);
        return (d == 1) ? 3 : 1;
    endfunction

    function automatic logic [31:0] seed(input int w);
        return (w == 4) ? 32'hDEADBEEF : ((32'(w) * 32'h0101_0101) ^ 32'hC3C3_0000);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] ws);
        logic [31:0] v;
        v = old;
        for (int b = 0; b < 4; b++)
            if (ws[b]) v[8*b +: 8] = wd[8*b +: 8];
        return v;
    endfunction

    function automatic logic [31:0] mm_word(input logic [9:0] a);
        return mm_wr[a] ? mm[a] : seed(int'(a));
    endfunction

    // RAM model: read data is valid only exactly LATENCY cycles after mem_en.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (mem_en[d]) begin
                if (mem_wstrb[d] != 4'h0) begin
                    mm[mem_addr[d]]    <= merge(mm_word(mem_addr[d]), mem_wdata[d], mem_wstrb[d]);
                    mm_wr[mem_addr[d]] <= 1'b1;
                end else begin
                    rd_due[d] <= cyc + lat_of(d);
                    rd_val[d] <= mm_word(mem_addr[d]);
                end
            end
        end
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++)
            mem_rdata[d] <= (rd_due[d] == cyc) ? rd_val[d] : $urandom();
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (LATENCY=%0d)", tag, obs, exp, lat_of(cur));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++) begin
                req[d][p] = 1'b0; addr[d][p] = '0; wdata[d][p] = '0; wstrb[d][p] = '0;
            end
        step();
        step();
        chk("rst_busy",   busy[cur], 0);
        chk("rst_mem_en", mem_en[cur], 0);
        chk("rst_ready",  {ready[cur][0], ready[cur][1]}, 0);
        chk("rst_rdata",  {rdata[cur][0], rdata[cur][1]}, 0);
        chk("rst_mem",    {mem_addr[cur], mem_wdata[cur], mem_wstrb[cur]}, 0);
        rst = 1'b0;
        exp_prio  = 0;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
    endtask

    task automatic txn(input int p, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] ws, input bit drop);
        int         n;
        int         en_cnt;
        bit         got;
        logic [9:0] w;
        w = a[11:2];
        addr[cur][p] = a; wdata[cur][p] = wd; wstrb[cur][p] = ws; req[cur][p] = 1'b1;
        n = 0; en_cnt = 0; got = 1'b0;
        while (!got && n < 30) begin
            step();
            n++;
            if (drop && n == 1) req[cur][p] = 1'b0;
            chk("ready_other", ready[cur][1-p], 0);
            if (mem_en[cur]) begin
                en_cnt++;
                chk("mem_addr",  mem_addr[cur], w);
                chk("mem_wdata", mem_wdata[cur], wd);
                chk("mem_wstrb", mem_wstrb[cur], ws);
                chk("busy_issue", busy[cur], 1);
            end else begin
                chk("wstrb_quiet", mem_wstrb[cur], 0);
            end
            got = ready[cur][p];
        end
        req[cur][p] = 1'b0;
        chk("latency", n, lat_of(cur) + 2);
        chk("mem_en_count", en_cnt, 1);
        if (ws == 4'h0) exp_rd[p] = ref_mem[w];
        else            ref_mem[w] = merge(ref_mem[w], wd, ws);
        chk("rdata_own",   rdata[cur][p], exp_rd[p]);
        chk("rdata_other", rdata[cur][1-p], exp_rd[1-p]);
        exp_prio = 1 - p;
        step();
    endtask

    task automatic both(input int n_tx);
        int          k;
        int          n;
        int          last;
        logic [31:0] a [2];
        a[0] = 32'h100;
        a[1] = 32'h104;
        for (int p = 0; p < 2; p++) begin
            addr[cur][p] = a[p]; wdata[cur][p] = '0; wstrb[cur][p] = '0; req[cur][p] = 1'b1;
        end
        k = 0; n = 0; last = 0;
        while (k < n_tx && n < 100) begin
            step();
            n++;
            chk("ready_excl", ready[cur][0] & ready[cur][1], 0);
            for (int q = 0; q < 2; q++) begin
                if (ready[cur][q]) begin
                    chk("grant_order", q, exp_prio);
                    chk("ready_spacing", n - last, (k == 0) ? lat_of(cur) + 2 : lat_of(cur) + 3);
                    exp_rd[q] = ref_mem[a[q][11:2]];
                    chk("both_rdata", rdata[cur][q], exp_rd[q]);
                    exp_prio = 1 - q;
                    last = n;
                    k++;
                end
            end
        end
        req[cur][0] = 1'b0;
        req[cur][1] = 1'b0;
        chk("both_count", k, n_tx);
        step();
    endtask

    initial begin
        int          rp;
        logic [31:0] ra;
        logic [31:0] rw;
        logic [3:0]  rs;
        rst    = 1'b1;
        n_chk  = 0;
        n_fail = 0;
        cur    = 0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = seed(i);

        for (int d = 0; d < 2; d++) begin
            cur = d;
            do_reset();

            txn(0, 32'h10, 32'h0, 4'h0, 1'b0);
            chk("first_read", rdata[cur][0], 32'hDEADBEEF);
            txn(1, 32'h8, 32'h1234_5678, 4'b0011, 1'b0);
            txn(1, 32'h8, 32'h0, 4'h0, 1'b0);

            for (int k = 0; k < 8; k++) begin
                rp = int'($urandom_range(0, 1));
                ra = $urandom();
                ra[11:2] = 10'($urandom_range(8, 23));
                rw = $urandom();
                rs = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
                txn(rp, ra, rw, rs, 1'b0);
            end

            do_reset();
            both(4);

            addr[cur][0] = 32'h20; wdata[cur][0] = '0; wstrb[cur][0] = '0; req[cur][0] = 1'b1;
            step();
            step();
            chk("wait_busy", busy[cur], 1);
            rst = 1'b1;
            #1;
            chk("async_busy",   busy[cur], 0);
            chk("async_mem_en", mem_en[cur], 0);
            chk("async_ready",  {ready[cur][0], ready[cur][1]}, 0);
            req[cur][0] = 1'b0;
            step();
            rst = 1'b0;
            exp_prio  = 0;
            exp_rd[0] = '0;
            exp_rd[1] = '0;
            for (int k = 0; k < lat_of(cur) + 4; k++) begin
                step();
                chk("no_ready_after_rst", {ready[cur][0], ready[cur][1], busy[cur]}, 0);
            end
            both(2);

            txn(1, 32'h30, 32'h0, 4'h0, 1'b1);
            for (int k = 0; k < 6; k++) begin
                step();
                chk("idle_after_drop", {busy[cur], mem_en[cur]}, 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous RAM between two requesters.
- Port m0 is the CPU instruction-fetch side; port m1 is the CPU data side or the program loader.
- Uses round-robin arbitration, a per-port req/ready handshake, registered memory commands and a configurable memory read latency.
- Sits between the CPU memory ports and the unified block RAM.

Parameters:
- MEM_AW, 10, memory word-address width; mem_addr = captured addr[MEM_AW+1:2].
- LATENCY, 1, cycles from the mem_en cycle to valid mem_rdata; legal range 1..4.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- m0_req  in  1  port 0 transaction request; held high until m0_ready.
- m0_addr  in  32  port 0 byte address; bits [1:0] ignored.
- m0_wdata  in  32  port 0 write data.
- m0_wstrb  in  4  port 0 byte write enables; 0 means read.
- m0_ready  out  1  one-cycle completion pulse for port 0.
- m0_rdata  out  32  port 0 read data; registered.
- m1_req, m1_addr, m1_wdata, m1_wstrb, m1_ready, m1_rdata: identical to port 0, for port 1.
- mem_en  out  1  memory access strobe; exactly one cycle per transaction.
- mem_addr  out  MEM_AW  memory word address.
- mem_wdata  out  32  memory write data.
- mem_wstrb  out  4  memory byte write enables.
- mem_rdata  in  32  memory read data; valid LATENCY cycles after the mem_en cycle.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst=1): state=IDLE, prio=0, cnt=0.
  - All outputs go to 0, including m*_rdata, mem_* and busy.
  - Any in-flight transaction is dropped with no ready pulse; mem_en falls immediately.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- FSM IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
- IDLE:
  - If neither req is high, stay in IDLE.
  - If exactly one req is high, grant that port.
  - If both are high, grant port `prio`.
  - On a grant: capture addr, wdata and wstrb of the granted port into command registers, record the grant index, set prio = the other port, go to ISSUE.
- ISSUE (1 cycle): mem_en=1, and mem_addr/mem_wdata/mem_wstrb carry the captured command. Load cnt=LATENCY, go to WAIT.
- WAIT:
  - mem_en=0 and mem_wstrb=0; mem_addr/mem_wdata hold their values.
  - cnt decrements each cycle.
  - In the cycle where cnt==1:
    - For a read, mem_rdata is captured into the granted port's rdata register.
    - For a write, rdata is left unchanged.
    - Go to DONE.
- DONE (1 cycle): the granted port's ready=1 and the other port's ready=0. Go to IDLE.
- Latency: req first sampled high in IDLE at cycle T -> mem_en at T+1 -> ready at T+2+LATENCY. With LATENCY=1, ready is at T+3.
- Minimum spacing between ready pulses is LATENCY+3 cycles.
- Handshake:
  - The requester keeps req, addr, wdata and wstrb stable until it sees ready. The arbiter uses only the values captured in IDLE.
  - A requester dropping req mid-transaction is ignored; the transaction completes and ready still pulses.
  - A req still high in the IDLE cycle after DONE is treated as a new transaction.
- Fairness: with both ports requesting continuously, grants alternate 0,1,0,1,... and neither port waits more than one transaction.
- rdata holds its last read result until the next read completes on that port. Writes and the other port's transactions never alter it.
- m0_ready and m1_ready are never high in the same cycle.
- Simultaneous events:
  - A new req arriving while busy waits in IDLE; it is not queued earlier.
  - rst has priority over everything.

Test Plan:
1. Reset, then m0 read addr=0x10 with mem model returning 0xDEADBEEF (LATENCY=1) -> mem_en for one cycle with mem_addr=4; m0_ready pulses 3 cycles after req is sampled; m0_rdata=0xDEADBEEF; m1_rdata stays 0.
2. m1 write addr=0x8, wdata=0x12345678, wstrb=4'b0011 -> one mem_en cycle with mem_addr=2, mem_wdata=0x12345678, mem_wstrb=0011; m1_ready pulses; m1_rdata unchanged.
3. m0 and m1 both held high from reset -> grant order 0,1,0,1 over 4 transactions; ready pulses spaced 4 cycles apart; never both ready in one cycle.
4. LATENCY=3 build, m0 read -> ready at T+5; data captured is the value presented 3 cycles after mem_en, not earlier values.
5. Assert rst during WAIT -> busy, mem_en and ready go to 0 asynchronously; no ready pulse afterwards; the next request after reset is granted to m0 when both request (prio=0).
6. m1 drops req in the ISSUE cycle -> transaction still completes with an m1_ready pulse; arbiter returns to IDLE and stays idle.
